net_frame_loader: RTL and testbench
===================================

# net_frame_loader

Streaming front end for the LUTNN `top` netlist. Accepts a binarized image as fixed-width beats over a valid/ready stream and assembles the `NET_I` vector. Waits a fixed settle time for the combinational network, captures `NET_O`, and returns a decoded class index over a second valid/ready stream. It sits between the host/DMA byte stream and `top`, replacing bench-driven stimulus in hardware.

## Interface
**Parameters**
- `NET_INPUTS`, default 400: width of the network input vector.
- `NET_OUTPUT`, default 10: width of the network output vector, one bit per class.
- `BEAT_W`, default 8: input beat width.
  - `NET_INPUTS % BEAT_W == 0` is required; `BEATS = NET_INPUTS/BEAT_W`, 50 at defaults.
- `SETTLE_CYCLES`, default 2: cycles allowed for `top` to settle. Must be ≥ 1.

**Ports**
- `CLK` in 1: single clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `IN_DATA` in `BEAT_W`: image beat.
- `IN_VALID` in 1: beat valid.
- `IN_LAST` in 1: final beat of frame.
- `IN_READY` out 1: loader accepts beats.
- `NET_I` out `NET_INPUTS`: registered vector to `top`.
- `NET_O` in `NET_OUTPUT`: combinational result from `top`.
- `RES_CLASS` out 4: decoded class index.
- `RES_MULTI` out 1: more than one `NET_O` bit was set.
- `RES_VALID` out 1: result valid.
- `RES_READY` in 1: consumer accepts result.
- `ERR` out 1: one-cycle pulse on framing error.
- `BUSY` out 1: high in SETTLE or RESULT.

## Operation
- **FSM states:** LOAD, SETTLE, RESULT. Reset state is LOAD.
- **LOAD**
  - `IN_READY=1`.
  - On handshake, beat `k` (`beat_cnt`) is written to `NET_I[BEAT_W*k +: BEAT_W]`. Beat 0 carries the LSBs.
  - Last beat (`beat_cnt==BEATS-1` with `IN_LAST=1`): go to SETTLE, clear `settle_cnt`, clear `beat_cnt`.
  - Early `IN_LAST` (`beat_cnt<BEATS-1`): pulse `ERR`, clear `beat_cnt`, stay in LOAD. The partial frame is discarded; it is overwritten by the next frame.
  - Missing `IN_LAST` at `beat_cnt==BEATS-1`: the beat is written, `ERR` pulses, `beat_cnt` clears, stay in LOAD.
- **SETTLE**
  - `IN_READY=0`; `NET_I` is held stable.
  - `settle_cnt` increments each cycle.
  - When `settle_cnt==SETTLE_CYCLES-1`: register `NET_O`, register the decode, set `RES_VALID`, go to RESULT.
- **RESULT**
  - `RES_VALID`, `RES_CLASS` and `RES_MULTI` are held until `RES_READY`.
  - On handshake: clear `RES_VALID`, go to LOAD.
  - `IN_VALID` is ignored while not in LOAD.
- **Decode rules**
  - `RES_CLASS` is the index of the lowest set bit of the captured `NET_O`.
  - `NET_O==0` gives `RES_CLASS=4'hF` and `RES_MULTI=0`.
  - `RES_MULTI=1` when the popcount is > 1.
- **Reset mid-operation:** all state cleared immediately, the partial frame is dropped, and no `ERR` is raised.

## Timing
- **Reset values:**
  - `NET_I=0`, `RES_CLASS=0`, `RES_MULTI=0`, `RES_VALID=0`, `ERR=0`, `BUSY=0`.
  - `IN_READY=1` (decoded from LOAD state).
- **Result latency:** last beat accepted at edge `t` → `RES_VALID` high after edge `t+SETTLE_CYCLES`.
- **Return to LOAD:** result handshake at edge `u` → `IN_READY=1` in cycle `u+1`.
- **Minimum frame period** with no stalls: `BEATS+SETTLE_CYCLES+1` cycles, 53 at defaults.
- **Combinational paths:** `IN_READY` and `BUSY` are decoded from state only. There is no combinational path from the `IN_*` ports to the `RES_*` ports.

## Configuration
- **Macro:** `NET_LOADER_RAW_EN`.
- **Defined:** adds output port `RES_RAW [NET_OUTPUT-1:0]`.
  - Carries the captured `NET_O`, valid with `RES_VALID`.
  - Reset value 0.
- **Undefined:** the port and its register are absent; decode behaviour is unchanged.

## Structure
- **Shared package `net_pkg`:**
  - `NET_INPUTS` and `NET_OUTPUT` constants.
  - `CLS_W=4`.
  - `CLS_NONE=4'hF`.
  - State enum `loader_state_t {S_LOAD, S_SETTLE, S_RESULT}`.
- **Sub-module `net_class_decode`:** combinational. Input `NET_OUTPUT` bits; outputs class, none and multi.

## Test plan
Benches use a stub `top` model with a programmable `NET_O`.

- **Nominal seven:** stream the 400-bit 20x20 "seven" pattern as 50 beats, stub drives `NET_O=10'b0010000000`.
  - `NET_I` equals the pattern.
  - `RES_VALID` rises 2 cycles after the last beat.
  - `RES_CLASS=7`, `RES_MULTI=0`.
- **Result backpressure:** hold `RES_READY=0` for 10 cycles with `IN_VALID=1`.
  - `RES_VALID` and the class stay stable.
  - `IN_READY=0` and no beats are consumed.
  - `RES_READY` pulse → `IN_READY=1` on the next cycle.
- **Framing errors:** `IN_LAST` on beat 20 → one-cycle `ERR`, no `RES_VALID`. Same for a frame missing `IN_LAST` at beat 49. A following good "two" frame with `NET_O=10'b0000000100` gives `RES_CLASS=2`.
- **Decode edges:**
  - `NET_O=0` → `RES_CLASS=15`, `RES_MULTI=0`.
  - `NET_O=10'b0000010010` → `RES_CLASS=1`, `RES_MULTI=1`.
  - `NET_O=10'b1000000000` → `RES_CLASS=9`.
- **Reset and throughput:**
  - `RST_N` low asynchronously at beat 30 → all outputs at reset values before the next edge; the next full frame decodes correctly.
  - Back-to-back frames with `RES_READY=1` → one result every 53 cycles.
  - With `NET_LOADER_RAW_EN`, `RES_RAW` equals the stub `NET_O`.

Source files
------------

// File: rtl/net_pkg.sv
// Shared constants, class encoding and loader state type for the LUTNN front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package net_pkg;

    localparam int NET_INPUTS = 400;
    localparam int NET_OUTPUT = 10;

    // Class index width and the code returned when no output bit is set.
    localparam int             CLS_W    = 4;
    localparam logic [CLS_W-1:0] CLS_NONE = 4'hF;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SETTLE,
        S_RESULT
    } loader_state_t;

endpackage

// File: rtl/net_frame_loader_if.sv
// Image-beat input stream plus decoded-result output stream of the frame loader.
// Latency: n/a (wires only).
// Backpressure: IN_READY throttles the beat source; RES_READY holds the result.
// Ports: IN_DATA/IN_VALID/IN_LAST/IN_READY (beats), RES_CLASS/RES_MULTI/RES_VALID/RES_READY (result).
// Modports: master = host/consumer side, slave = loader side.
interface net_frame_loader_if #(
    parameter int BEAT_W = 8
);
    import net_pkg::*;

    logic [BEAT_W-1:0] IN_DATA;
    logic              IN_VALID;
    logic              IN_LAST;
    logic              IN_READY;

    logic [CLS_W-1:0]  RES_CLASS;
    logic              RES_MULTI;
    logic              RES_VALID;
    logic              RES_READY;

    modport master (
        output IN_DATA, IN_VALID, IN_LAST, RES_READY,
        input  IN_READY, RES_CLASS, RES_MULTI, RES_VALID
    );

    modport slave (
        input  IN_DATA, IN_VALID, IN_LAST, RES_READY,
        output IN_READY, RES_CLASS, RES_MULTI, RES_VALID
    );

endinterface

// File: rtl/net_class_decode.sv
// Decodes the network output vector to the lowest set class index, none and multi flags.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (NET_O bits) in; cls (CLS_NONE when vec==0), none, multi (popcount > 1) out.
module net_class_decode import net_pkg::*; #(
    parameter int N = NET_OUTPUT
) (
    input  logic [N-1:0]     vec,
    output logic [CLS_W-1:0] cls,
    output logic             none,
    output logic             multi
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        cls = CLS_NONE;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                cls = CLS_W'(i);
            end
        end
    end

    assign none  = (vec == '0);
    assign multi = ($countones(vec) > 1);

endmodule

// File: rtl/net_frame_loader.sv
// Assembles NET_I from BEAT_W-wide beats, waits SETTLE_CYCLES for the network, returns the decoded class.
// Latency: last beat accepted at edge t -> RES_VALID after edge t+SETTLE_CYCLES; frame period BEATS+SETTLE_CYCLES+1.
// Backpressure: IN_READY only in LOAD; result held until RES_READY, beats ignored meanwhile.
// Ports: CLK, RST_N (async active-low), io (slave stream bundle), NET_I/NET_O to/from the netlist,
//        ERR one-cycle framing-error pulse, BUSY high in SETTLE/RESULT.
// Option: NET_LOADER_RAW_EN adds RES_RAW, the captured NET_O, valid with RES_VALID.
module net_frame_loader #(
    parameter int NET_INPUTS    = net_pkg::NET_INPUTS,
    parameter int NET_OUTPUT    = net_pkg::NET_OUTPUT,
    parameter int BEAT_W        = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    net_frame_loader_if.slave     io,
    output logic [NET_INPUTS-1:0] NET_I,
    input  logic [NET_OUTPUT-1:0] NET_O,
    output logic                  ERR,
    output logic                  BUSY
`ifdef NET_LOADER_RAW_EN
    ,
    output logic [NET_OUTPUT-1:0] RES_RAW
`endif
);
    import net_pkg::*;

    // NET_INPUTS must be a multiple of BEAT_W and SETTLE_CYCLES at least 1.
    localparam int BEATS = NET_INPUTS / BEAT_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SCW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    loader_state_t    state, state_nxt;
    logic [BCW-1:0]   beat_cnt;
    logic [SCW-1:0]   settle_cnt;
    logic             in_hs, capture, res_hs, last_beat;

    logic [CLS_W-1:0] dec_cls;
    logic             dec_none, dec_multi;

    net_class_decode #(.N(NET_OUTPUT)) u_decode (
        .vec   (NET_O),
        .cls   (dec_cls),
        .none  (dec_none),
        .multi (dec_multi)
    );

    // Both are pure state decodes: no path from IN_* into the ready/busy outputs.
    assign io.IN_READY = (state == S_LOAD);
    assign BUSY        = (state != S_LOAD);
    assign last_beat   = (beat_cnt == BCW'(BEATS - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_hs     = 1'b0;
        capture   = 1'b0;
        res_hs    = 1'b0;
        case (state)
            S_LOAD: begin
                in_hs = io.IN_VALID;
                if (in_hs && last_beat && io.IN_LAST) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SCW'(SETTLE_CYCLES - 1)) begin
                    capture   = 1'b1;
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (io.RES_READY) begin
                    res_hs    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            beat_cnt     <= '0;
            settle_cnt   <= '0;
            NET_I        <= '0;
            ERR          <= 1'b0;
            io.RES_VALID <= 1'b0;
            io.RES_CLASS <= '0;
            io.RES_MULTI <= 1'b0;
        end else begin
            // Framing error: IN_LAST disagrees with the beat position (early or missing).
            ERR <= in_hs && (io.IN_LAST != last_beat);

            if (in_hs) begin
                NET_I[int'(beat_cnt) * BEAT_W +: BEAT_W] <= io.IN_DATA;
                // Any IN_LAST or the final slot restarts the frame; an aborted
                // partial frame is simply overwritten by the next one.
                beat_cnt <= (last_beat || io.IN_LAST) ? '0 : beat_cnt + 1'b1;
            end

            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;

            if (capture) begin
                io.RES_VALID <= 1'b1;
                io.RES_CLASS <= dec_none ? CLS_NONE : dec_cls;
                io.RES_MULTI <= dec_multi;
            end else if (res_hs) begin
                io.RES_VALID <= 1'b0;
            end
        end
    end

`ifdef NET_LOADER_RAW_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RES_RAW <= '0;
        end else if (capture) begin
            RES_RAW <= NET_O;
        end
    end
`endif

endmodule

// File: tb/tb_net_frame_loader.sv
// Directed plus randomized bench for net_frame_loader with a programmable NET_O stub.
// Latency: n/a.
// Backpressure: exercises result stalls and back-to-back frames.
module tb_net_frame_loader;
    import net_pkg::*;

    localparam int NI     = 400;
    localparam int NO     = 10;
    localparam int BW     = 8;
    localparam int BEATS  = NI / BW;
    localparam int SETTLE = 2;
    localparam int PERIOD = BEATS + SETTLE + 1;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b1;
    logic [NI-1:0] NET_I;
    logic [NO-1:0] net_o = '0;
    logic          ERR;
    logic          BUSY;
`ifdef NET_LOADER_RAW_EN
    logic [NO-1:0] res_raw;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    net_frame_loader_if #(.BEAT_W(BW)) io ();

    net_frame_loader #(
        .NET_INPUTS    (NI),
        .NET_OUTPUT    (NO),
        .BEAT_W        (BW),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .io    (io),
        .NET_I (NET_I),
        .NET_O (net_o),
        .ERR   (ERR),
        .BUSY  (BUSY)
`ifdef NET_LOADER_RAW_EN
        ,
        .RES_RAW (res_raw)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] exp_cls(input logic [NO-1:0] v);
        for (int i = 0; i < NO; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'hF;
    endfunction

    function automatic logic exp_multi(input logic [NO-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NO; i++) begin
            if (v[i]) n++;
        end
        return (n > 1);
    endfunction

    function automatic logic [NI-1:0] rand_img();
        logic [NI-1:0] p;
        for (int i = 0; i < NI; i++) p[i] = 1'($urandom_range(0, 1));
        return p;
    endfunction

    // 20x20 "seven": a horizontal bar and a slanted stroke.
    function automatic logic [NI-1:0] seven_img();
        logic [NI-1:0] p;
        p = '0;
        for (int c = 4; c < 16; c++) begin
            p[2*20 + c] = 1'b1;
            p[3*20 + c] = 1'b1;
        end
        for (int r = 4; r < 18; r++) begin
            p[r*20 + 15 - (r-4)/2] = 1'b1;
            p[r*20 + 14 - (r-4)/2] = 1'b1;
        end
        return p;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [NI-1:0] obs, input logic [NI-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one beat and wait (bounded) until an edge accepts it.
    task automatic send_beat(input logic [BW-1:0] d, input logic last);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        io.IN_DATA  = d;
        io.IN_VALID = 1'b1;
        io.IN_LAST  = last;
        while (!acc && n < 200) begin
            acc = io.IN_READY;
            tick();
            n++;
        end
        check("beat_accept", acc, 1'b1);
        io.IN_VALID = 1'b0;
        io.IN_LAST  = 1'b0;
    endtask

    task automatic send_frame(input logic [NI-1:0] img, input int nbeats, input int last_idx);
        for (int k = 0; k < nbeats; k++) begin
            send_beat(img[k*BW +: BW], (k == last_idx));
        end
    endtask

    // Full good frame: checks latency, NET_I, decode, optional stall, handshake return.
    task automatic run_frame(input logic [NI-1:0] img, input logic [NO-1:0] no, input int hold);
        net_o = no;
        send_frame(img, BEATS, BEATS - 1);
        check("valid_at_last", io.RES_VALID, 1'b0);
        check("busy_settle", BUSY, 1'b1);
        for (int i = 1; i < SETTLE; i++) begin
            tick();
            check("valid_early", io.RES_VALID, 1'b0);
        end
        tick();
        check("valid_latency", io.RES_VALID, 1'b1);
        check("net_i", NET_I, img);
        check("res_class", io.RES_CLASS, exp_cls(no));
        check("res_multi", io.RES_MULTI, exp_multi(no));
        check("err_quiet", ERR, 1'b0);
`ifdef NET_LOADER_RAW_EN
        check("res_raw", res_raw, no);
`endif
        for (int i = 0; i < hold; i++) begin
            io.IN_VALID = 1'b1;
            io.IN_DATA  = 8'($urandom);
            tick();
            check("hold_valid", io.RES_VALID, 1'b1);
            check("hold_class", io.RES_CLASS, exp_cls(no));
            check("hold_multi", io.RES_MULTI, exp_multi(no));
            check("hold_in_ready", io.IN_READY, 1'b0);
            check("hold_net_i", NET_I, img);
        end
        io.RES_READY = 1'b1;
        tick();
        io.RES_READY = 1'b0;
        io.IN_VALID  = 1'b0;
        check("ret_in_ready", io.IN_READY, 1'b1);
        check("ret_valid_low", io.RES_VALID, 1'b0);
        check("ret_busy_low", BUSY, 1'b0);
        check("ret_net_i", NET_I, img);
    endtask

    // ---------------- stimulus ----------------
    logic [NI-1:0] imgs [3];
    logic [NO-1:0] nos  [3];
    int            rcyc [3];
    int            fi, bi, results, cyc;
    logic          acc_t;

    initial begin
        io.IN_DATA   = '0;
        io.IN_VALID  = 1'b0;
        io.IN_LAST   = 1'b0;
        io.RES_READY = 1'b0;

        // Reset values
        #2 RST_N = 1'b0;
        #2;
        check("rst_net_i", NET_I, '0);
        check("rst_class", io.RES_CLASS, 4'h0);
        check("rst_multi", io.RES_MULTI, 1'b0);
        check("rst_valid", io.RES_VALID, 1'b0);
        check("rst_err", ERR, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_in_ready", io.IN_READY, 1'b1);
        tick();
        RST_N = 1'b1;
        tick();

        // Nominal seven with a 10-cycle result stall
        run_frame(seven_img(), 10'b0010000000, 10);

        // Early IN_LAST on beat 20
        net_o = 10'b0000000100;
        send_frame(rand_img(), 21, 20);
        check("err_early", ERR, 1'b1);
        tick();
        check("err_early_pulse", ERR, 1'b0);
        check("err_early_novalid", io.RES_VALID, 1'b0);
        check("err_early_ready", io.IN_READY, 1'b1);

        // Missing IN_LAST at beat 49
        send_frame(rand_img(), BEATS, -1);
        check("err_missing", ERR, 1'b1);
        tick();
        check("err_missing_pulse", ERR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_missing_novalid", io.RES_VALID, 1'b0);
            check("err_missing_idle", BUSY, 1'b0);
        end

        // Good "two" frame after the errors
        run_frame(rand_img(), 10'b0000000100, 0);

        // Decode edges
        run_frame(rand_img(), 10'b0000000000, 0);
        run_frame(rand_img(), 10'b0000010010, 0);
        run_frame(rand_img(), 10'b1000000000, 1);

        // Random frames
        for (int f = 0; f < 5; f++) begin
            run_frame(rand_img(), 10'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset at beat 30
        send_frame(rand_img(), 30, -1);
        io.IN_VALID = 1'b1;
        io.IN_DATA  = 8'hA5;
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_net_i", NET_I, '0);
        check("mid_rst_class", io.RES_CLASS, 4'h0);
        check("mid_rst_multi", io.RES_MULTI, 1'b0);
        check("mid_rst_valid", io.RES_VALID, 1'b0);
        check("mid_rst_err", ERR, 1'b0);
        check("mid_rst_busy", BUSY, 1'b0);
        check("mid_rst_in_ready", io.IN_READY, 1'b1);
        io.IN_VALID = 1'b0;
        #2 RST_N = 1'b1;
        tick();
        check("post_rst_err", ERR, 1'b0);
        run_frame(rand_img(), 10'b0000100000, 0);

        // Back-to-back throughput with RES_READY held high
        for (int f = 0; f < 3; f++) begin
            imgs[f] = rand_img();
            nos[f]  = 10'($urandom_range(0, 1023));
        end
        io.RES_READY = 1'b1;
        fi = 0; bi = 0; results = 0; cyc = 0;
        while (results < 3 && cyc < 1000) begin
            if (fi < 3) begin
                io.IN_VALID = 1'b1;
                io.IN_DATA  = imgs[fi][bi*BW +: BW];
                io.IN_LAST  = (bi == BEATS - 1);
            end else begin
                io.IN_VALID = 1'b0;
                io.IN_LAST  = 1'b0;
            end
            net_o = nos[results];
            acc_t = io.IN_READY;
            tick();
            cyc++;
            if (acc_t && fi < 3) begin
                if (bi == BEATS - 1) begin
                    bi = 0;
                    fi++;
                end else begin
                    bi++;
                end
            end
            if (io.RES_VALID) begin
                rcyc[results] = cyc;
                check("tput_class", io.RES_CLASS, exp_cls(nos[results]));
                check("tput_multi", io.RES_MULTI, exp_multi(nos[results]));
                check("tput_net_i", NET_I, imgs[results]);
                results++;
            end
        end
        io.IN_VALID  = 1'b0;
        io.IN_LAST   = 1'b0;
        io.RES_READY = 1'b0;
        check("tput_results", results, 3);
        if (results == 3) begin
            check("tput_period_1", rcyc[1] - rcyc[0], PERIOD);
            check("tput_period_2", rcyc[2] - rcyc[1], PERIOD);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
